// File: rtl/decode_issue_stage.sv
// Decode/issue stage: instruction decode, register file, load-use hazard stall and ALU-side output register.
// Optional macro DECODE_WT_BYPASS_EN enables write-through bypass of the writeback port into operand reads.
module decode_issue_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned PC_WIDTH   = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [31:0]           instruction,
  input  logic                  flush,
  input  logic                  block_pipe_data_cache,
  input  logic                  block_pipe_instr_cache,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  EN_REG_FETCH,
  output logic                  EN_REG_DECODE,
  output logic                  out_valid,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [ADDR_WIDTH-1:0] addrA,
  output logic [ADDR_WIDTH-1:0] addrB,
  output logic [ADDR_WIDTH-1:0] regD,
  output logic [1:0]            ALU_OP,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic                  MEM_TO_REG,
  output logic                  is_branch,
  output logic                  is_immediate
);

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;

  logic [5:0]            opcode;
  logic [ADDR_WIDTH-1:0] ra, rb, rd;
  logic [DATA_WIDTH-1:0] imm_ext;

  assign opcode  = instruction[31:26];
  assign ra      = instruction[21 +: ADDR_WIDTH];
  assign rb      = instruction[16 +: ADDR_WIDTH];
  assign rd      = instruction[11 +: ADDR_WIDTH];
  assign imm_ext = DATA_WIDTH'($signed(instruction[15:0]));

  logic                  dec_valid, uses_a, uses_b;
  logic [1:0]            dec_alu_op;
  logic [ADDR_WIDTH-1:0] dec_regd;
  logic                  dec_wb, dec_mr, dec_mw, dec_m2r, dec_br, dec_imm;

  // Opcode decode; unknown opcodes decode to an invalid bubble
  always_comb begin
    dec_valid  = 1'b0;
    uses_a     = 1'b0;
    uses_b     = 1'b0;
    dec_alu_op = 2'b00;
    dec_regd   = '0;
    dec_wb     = 1'b0;
    dec_mr     = 1'b0;
    dec_mw     = 1'b0;
    dec_m2r    = 1'b0;
    dec_br     = 1'b0;
    dec_imm    = 1'b0;
    case (opcode)
      OP_ALU: begin
        dec_valid = 1'b1; uses_a = 1'b1; uses_b = 1'b1;
        dec_alu_op = instruction[1:0]; dec_wb = 1'b1; dec_regd = rd;
      end
      OP_ADDI: begin
        dec_valid = 1'b1; uses_a = 1'b1;
        dec_imm = 1'b1; dec_wb = 1'b1; dec_regd = rb;
      end
      OP_LD: begin
        dec_valid = 1'b1; uses_a = 1'b1;
        dec_mr = 1'b1; dec_m2r = 1'b1; dec_wb = 1'b1; dec_imm = 1'b1; dec_regd = rb;
      end
      OP_ST: begin
        dec_valid = 1'b1; uses_a = 1'b1; uses_b = 1'b1;
        dec_mw = 1'b1; dec_imm = 1'b1;
      end
      OP_BEQ: begin
        dec_valid = 1'b1; uses_a = 1'b1; uses_b = 1'b1;
        dec_br = 1'b1; dec_imm = 1'b1;
      end
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Register file; entry 0 is never written so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  always_comb begin
    rdata_a = (ra == '0) ? '0 : regs[ra];
    rdata_b = (rb == '0) ? '0 : regs[rb];
`ifdef DECODE_WT_BYPASS_EN
    if (wb_en && (wb_addr == ra) && (ra != '0)) rdata_a = wb_data;
    if (wb_en && (wb_addr == rb) && (rb != '0)) rdata_b = wb_data;
`endif
  end

  logic freeze, hazard;

  assign freeze = block_pipe_data_cache | block_pipe_instr_cache;
  assign hazard = in_valid & out_valid & MEM_R_EN & (regD != '0) &
                  (((regD == ra) & uses_a) | ((regD == rb) & uses_b));

  assign EN_REG_FETCH  = ~(freeze | hazard);
  assign EN_REG_DECODE = ~(freeze | hazard);

  // ALU-side register: freeze holds, kill conditions load a zeroed bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0; pc_out <= '0; data_a <= '0; data_b <= '0; imm <= '0;
      addrA <= '0; addrB <= '0; regD <= '0; ALU_OP <= 2'b00;
      WB_EN <= 1'b0; MEM_R_EN <= 1'b0; MEM_W_EN <= 1'b0; MEM_TO_REG <= 1'b0;
      is_branch <= 1'b0; is_immediate <= 1'b0;
    end else if (!freeze) begin
      if (flush || hazard || !in_valid || !dec_valid) begin
        out_valid <= 1'b0; pc_out <= '0; data_a <= '0; data_b <= '0; imm <= '0;
        addrA <= '0; addrB <= '0; regD <= '0; ALU_OP <= 2'b00;
        WB_EN <= 1'b0; MEM_R_EN <= 1'b0; MEM_W_EN <= 1'b0; MEM_TO_REG <= 1'b0;
        is_branch <= 1'b0; is_immediate <= 1'b0;
      end else begin
        out_valid <= 1'b1; pc_out <= pc_in; data_a <= rdata_a; data_b <= rdata_b;
        imm <= imm_ext; addrA <= ra; addrB <= rb; regD <= dec_regd; ALU_OP <= dec_alu_op;
        WB_EN <= dec_wb; MEM_R_EN <= dec_mr; MEM_W_EN <= dec_mw; MEM_TO_REG <= dec_m2r;
        is_branch <= dec_br; is_immediate <= dec_imm;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized self-checking bench for decode_issue_stage against an instruction-level reference model.
// Build with DECODE_WT_BYPASS_EN defined to check the write-through variant.
module tb_decode_issue_stage;

`ifdef DECODE_WT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, reset, in_valid, flush, bd, bi, wb_en;
  logic [31:0] pc_in, instruction, wb_data;
  logic [4:0]  wb_addr;
  logic        EN_REG_FETCH, EN_REG_DECODE, out_valid;
  logic [31:0] pc_out, data_a, data_b, imm;
  logic [4:0]  addrA, addrB, regD;
  logic [1:0]  ALU_OP;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG, is_branch, is_immediate;

  decode_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .instruction(instruction),
    .flush(flush), .block_pipe_data_cache(bd), .block_pipe_instr_cache(bi),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .EN_REG_FETCH(EN_REG_FETCH), .EN_REG_DECODE(EN_REG_DECODE), .out_valid(out_valid),
    .pc_out(pc_out), .data_a(data_a), .data_b(data_b), .imm(imm),
    .addrA(addrA), .addrB(addrB), .regD(regD), .ALU_OP(ALU_OP),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .MEM_TO_REG(MEM_TO_REG),
    .is_branch(is_branch), .is_immediate(is_immediate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: architectural register values and the expected issued instruction
  logic [31:0] mregs [32];
  logic        m_valid, m_wb, m_mr, m_mw, m_m2r, m_br, m_imf;
  logic [31:0] m_pc, m_da, m_db, m_imm;
  logic [4:0]  m_a, m_b, m_d;
  logic [1:0]  m_aluop;
  logic        last_en;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0; m_imf = 0;
    m_pc = 0; m_da = 0; m_db = 0; m_imm = 0; m_a = 0; m_b = 0; m_d = 0; m_aluop = 0;
  endtask

  function automatic logic [31:0] read_val(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (BYP && we && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic check_outputs();
    check("out_valid",    64'(out_valid),    64'(m_valid));
    check("pc_out",       64'(pc_out),       64'(m_pc));
    check("data_a",       64'(data_a),       64'(m_da));
    check("data_b",       64'(data_b),       64'(m_db));
    check("imm",          64'(imm),          64'(m_imm));
    check("addrA",        64'(addrA),        64'(m_a));
    check("addrB",        64'(addrB),        64'(m_b));
    check("regD",         64'(regD),         64'(m_d));
    check("ALU_OP",       64'(ALU_OP),       64'(m_aluop));
    check("WB_EN",        64'(WB_EN),        64'(m_wb));
    check("MEM_R_EN",     64'(MEM_R_EN),     64'(m_mr));
    check("MEM_W_EN",     64'(MEM_W_EN),     64'(m_mw));
    check("MEM_TO_REG",   64'(MEM_TO_REG),   64'(m_m2r));
    check("is_branch",    64'(is_branch),    64'(m_br));
    check("is_immediate", 64'(is_immediate), 64'(m_imf));
  endtask

  // One clock cycle: drive at negedge, check enables, advance model, check registered outputs
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic fl, input logic dc, input logic ic,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0] op;
    logic [4:0] ra, rb, rd;
    logic known, usesa, usesb, haz, frz;
    @(negedge clk);
    in_valid = iv; pc_in = pc; instruction = ins; flush = fl; bd = dc; bi = ic;
    wb_en = we; wb_addr = wa; wb_data = wd;
    op = ins[31:26]; ra = ins[25:21]; rb = ins[20:16]; rd = ins[15:11];
    known = (op <= 6'd4);
    usesa = known;
    usesb = (op == 6'd0) || (op == 6'd3) || (op == 6'd4);
    haz = iv && m_valid && m_mr && (m_d != 0) && ((m_d == ra && usesa) || (m_d == rb && usesb));
    frz = dc || ic;
    #1;
    last_en = EN_REG_FETCH;
    check("en_fetch",  64'(EN_REG_FETCH),  64'(!(frz || haz)));
    check("en_decode", 64'(EN_REG_DECODE), 64'(!(frz || haz)));
    if (!frz) begin
      if (fl || haz || !iv || !known) begin
        m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0; m_imf = 0;
        m_pc = 0; m_da = 0; m_db = 0; m_imm = 0; m_a = 0; m_b = 0; m_d = 0; m_aluop = 0;
      end else begin
        m_valid = 1; m_pc = pc; m_a = ra; m_b = rb;
        m_da = read_val(ra, we, wa, wd);
        m_db = read_val(rb, we, wa, wd);
        m_imm = {{16{ins[15]}}, ins[15:0]};
        m_aluop = (op == 6'd0) ? ins[1:0] : 2'b00;
        m_wb  = (op <= 6'd2);
        m_mr  = (op == 6'd2);
        m_m2r = (op == 6'd2);
        m_mw  = (op == 6'd3);
        m_br  = (op == 6'd4);
        m_imf = (op != 6'd0);
        m_d   = (op == 6'd0) ? rd : ((op <= 6'd2) ? rb : 5'd0);
      end
    end
    @(posedge clk);
    #1;
    if (we && wa != 0) mregs[wa] = wd;
    check_outputs();
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [4:0] rd,
                                       input logic [1:0] fn);
    return {op, ra, rb, rd, 9'h0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [15:0] im);
    return {op, ra, rb, im};
  endfunction

  initial begin
    logic [31:0] rins;
    model_clear();
    last_en = 1'b0;
    reset = 0; in_valid = 0; pc_in = 0; instruction = 0; flush = 0; bd = 0; bi = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    #1;
    check_outputs();
    check("rst_en_fetch", 64'(EN_REG_FETCH), 64'd1);
    @(negedge clk); @(negedge clk);
    reset = 1;

    // ADDI r3, r0, 0xFFF0
    step(1, 32'h100, mk_i(6'd1, 5'd0, 5'd3, 16'hFFF0), 0, 0, 0, 0, 0, 0);
    check("addi_imm",  64'(imm),  64'hFFFF_FFF0);
    check("addi_regD", 64'(regD), 64'd3);

    // LD r4 then ALU r6 = r4 + r2: one stall bubble, then issue
    step(1, 32'h104, mk_i(6'd2, 5'd1, 5'd4, 16'h0010), 0, 0, 0, 0, 0, 0);
    step(1, 32'h108, mk_r(6'd0, 5'd4, 5'd2, 5'd6, 2'd0), 0, 0, 0, 0, 0, 0);
    check("lduse_stall_en", 64'(last_en), 64'd0);
    check("lduse_bubble",   64'(out_valid), 64'd0);
    step(1, 32'h108, mk_r(6'd0, 5'd4, 5'd2, 5'd6, 2'd0), 0, 0, 0, 0, 0, 0);
    check("lduse_issue_addrA", 64'(addrA), 64'd4);
    check("lduse_issue_en",    64'(last_en), 64'd1);

    // Same-cycle writeback of r7 while reading it
    step(1, 32'h10C, mk_r(6'd0, 5'd7, 5'd0, 5'd1, 2'd1), 0, 0, 0, 1, 5'd7, 32'hA5A5_A5A5);
    check("wt_bypass", 64'(data_a), BYP ? 64'hA5A5_A5A5 : 64'd0);

    // Write to r0 is discarded
    step(0, 32'h0, 32'h0, 0, 0, 0, 1, 5'd0, 32'h1234);
    step(1, 32'h110, mk_r(6'd0, 5'd0, 5'd7, 5'd2, 2'd2), 0, 0, 0, 0, 0, 0);
    check("r0_zero", 64'(data_a), 64'd0);

    // Freeze for 3 cycles with flush held, then one bubble
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h114, mk_i(6'd1, 5'd1, 5'd2, 16'h0001), 1, 0, 1, 0, 0, 0);
      check("freeze_hold", 64'(out_valid), 64'd1);
      check("freeze_en",   64'(last_en),   64'd0);
    end
    step(1, 32'h114, mk_i(6'd1, 5'd1, 5'd2, 16'h0001), 1, 0, 0, 0, 0, 0);
    check("flush_bubble", 64'(out_valid), 64'd0);

    // Write r5, issue a valid op, then reset mid-stream
    step(1, 32'h118, mk_i(6'd1, 5'd2, 5'd9, 16'h0002), 0, 0, 0, 1, 5'd5, 32'hDEAD_0005);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 0; flush = 0; bd = 0; bi = 0; wb_en = 0;
    #2 reset = 0;
    #1;
    model_clear();
    check_outputs();
    check("rst_mid_en", 64'(EN_REG_FETCH), 64'd1);
    @(negedge clk);
    reset = 1;
    step(1, 32'h200, mk_r(6'd0, 5'd5, 5'd0, 5'd1, 2'd0), 0, 0, 0, 0, 0, 0);
    check("r5_after_reset", 64'(data_a), 64'd0);

    // Randomized traffic on a narrow register range to provoke hazards and bypasses
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(6, 63));
      rins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
      step($urandom_range(0, 99) < 85, $urandom, rins,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
